// File: rtl/sha256_stream.sv
// sha256_stream: multi-block SHA-224/SHA-256 compression engine with a
// chaining H register, valid/ready block input and UNROLL rounds per clock.
module sha256_stream #(
  parameter int UNROLL    = 1,
  parameter bit SHA224_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  input  logic         mode,
  output logic         hash_valid,
  output logic [255:0] hash,
  output logic         busy
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("sha256_stream: UNROLL must be 1, 2 or 4");
  end

  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  state_t       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  word_t        w_q [16];
  word_t        w_d [16];
  word_t        v_q [8];
  word_t        v_d [8];
  word_t        h_q [8];
  word_t        h_d [8];
  word_t        rw  [16];
  word_t        rv  [8];
  logic         mode_q, mode_d;
  logic         last_q, last_d;
  logic         hv_q, hv_d;
  logic [255:0] hash_q, hash_d;
  logic         mode_in;

  assign mode_in    = SHA224_EN ? mode : 1'b0;
  assign blk_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign hash_valid = hv_q;
  assign hash       = hash_q;

  // UNROLL chained rounds; window w[0] always holds W[t] of the round.
  always_comb begin : rnd_p
    word_t t1, t2, nw;
    t1 = '0;
    t2 = '0;
    nw = '0;
    rw = w_q;
    rv = v_q;
    for (int u = 0; u < UNROLL; u++) begin
      t1 = rv[7] + bsig1(rv[4]) + ((rv[4] & rv[5]) ^ (~rv[4] & rv[6]))
         + K[cnt_q + 6'(u)] + rw[0];
      t2 = bsig0(rv[0])
         + ((rv[0] & rv[1]) ^ (rv[0] & rv[2]) ^ (rv[1] & rv[2]));
      rv[7] = rv[6];
      rv[6] = rv[5];
      rv[5] = rv[4];
      rv[4] = rv[3] + t1;
      rv[3] = rv[2];
      rv[2] = rv[1];
      rv[1] = rv[0];
      rv[0] = t1 + t2;
      nw = ssig1(rw[14]) + rw[9] + ssig0(rw[1]) + rw[0];
      for (int j = 0; j < 15; j++) rw[j] = rw[j + 1];
      rw[15] = nw;
    end
  end

  always_comb begin : nxt_p
    word_t        base [8];
    logic [255:0] hsum;
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    v_d     = v_q;
    h_d     = h_q;
    mode_d  = mode_q;
    last_d  = last_q;
    hash_d  = hash_q;
    hv_d    = 1'b0;
    hsum    = '0;
    for (int i = 0; i < 8; i++) begin
      if (blk_first) base[i] = mode_in ? IV224[i] : IV256[i];
      else           base[i] = h_q[i];
    end
    unique case (state_q)
      S_IDLE: begin
        if (blk_valid) begin
          for (int i = 0; i < 16; i++) w_d[i] = blk_data[511 - 32*i -: 32];
          v_d = base;
          if (blk_first) begin
            h_d    = base;
            mode_d = mode_in;
          end
          last_d  = blk_last;
          cnt_d   = '0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        w_d   = rw;
        v_d   = rv;
        cnt_d = cnt_q + 6'(UNROLL);
        if (cnt_q == 6'(64 - UNROLL)) state_d = S_FINAL;
      end
      S_FINAL: begin
        for (int i = 0; i < 8; i++) begin
          h_d[i] = h_q[i] + v_q[i];
          hsum[255 - 32*i -: 32] = h_d[i];
        end
        if (mode_q) hsum[31:0] = '0;
        if (last_q) begin
          hash_d = hsum;
          hv_d   = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      w_q     <= '{default: '0};
      v_q     <= '{default: '0};
      h_q     <= '{default: '0};
      mode_q  <= 1'b0;
      last_q  <= 1'b0;
      hv_q    <= 1'b0;
      hash_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      v_q     <= v_d;
      h_q     <= h_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      hv_q    <= hv_d;
      hash_q  <= hash_d;
    end
  end

endmodule

// File: tb/tb_sha256_stream.sv
// Bench for sha256_stream: UNROLL 1/2/4 instances checked every cycle
// against a whole-block SHA-256 model, plus known digest vectors.
module tb_sha256_stream;

  localparam int NI = 3;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV256 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] IV224 =
    256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;

  localparam logic [511:0] B_ABC   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_TWO1  = {
    448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071,
    32'h80000000, 32'h0};
  localparam logic [511:0] B_TWO2  = {448'h0, 64'h1c0};

  localparam logic [255:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_ABC224 =
    256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
  localparam logic [255:0] D_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NI-1:0] bv, bf, bl, bm, rdy, hv, bsy;
  logic [NI-1:0][511:0] bd;
  logic [NI-1:0][255:0] hs;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sha256_stream #(.UNROLL(1 << g), .SHA224_EN(1'b1)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .blk_valid  (bv[g]),
      .blk_ready  (rdy[g]),
      .blk_data   (bd[g]),
      .blk_first  (bf[g]),
      .blk_last   (bl[g]),
      .mode       (bm[g]),
      .hash_valid (hv[g]),
      .hash       (hs[g]),
      .busy       (bsy[g])
    );
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 block compression with a full 64-word schedule.
  function automatic logic [255:0] compress(input logic [255:0] hin,
                                            input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, gg, hh, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    {a, b, c, d, e, f, gg, hh} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & gg))
         + KT[t] + w[t];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = gg; gg = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hin[255:224], b + hin[223:192], c + hin[191:160],
            d + hin[159:128], e + hin[127:96], f + hin[95:64],
            gg + hin[63:32], hh + hin[31:0]};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Model: per instance, busy cycles left, chained H, latched mode/last.
  logic [NI-1:0][7:0]   rem;
  logic [NI-1:0][255:0] hch, hexp;
  logic [NI-1:0]        lastp, mode_l, hvexp;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem <= '0; hch <= '0; hexp <= '0;
      lastp <= '0; mode_l <= '0; hvexp <= '0;
    end else begin
      for (int g = 0; g < NI; g++) begin
        hvexp[g] <= 1'b0;
        if (rem[g] != 0) begin
          rem[g] <= rem[g] - 8'd1;
          if (rem[g] == 8'd1 && lastp[g]) begin
            hvexp[g] <= 1'b1;
            hexp[g]  <= mode_l[g] ? {hch[g][255:32], 32'h0} : hch[g];
          end
        end else if (bv[g]) begin
          rem[g]   <= 8'((64 >> g) + 1);
          lastp[g] <= bl[g];
          if (bf[g]) begin
            mode_l[g] <= bm[g];
            hch[g]    <= compress(bm[g] ? IV224 : IV256, bd[g]);
          end else begin
            hch[g] <= compress(hch[g], bd[g]);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input int g,
                       input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s[u%0d] got %h required %h", nm, g, act, exp);
    end
  endtask

  task automatic timeout(input string nm, input int g, input int n);
    n_tests++;
    n_fail++;
    $display("FAIL %s[u%0d] timeout: waited %0d cycles, required event", nm, g, n);
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      check("ready", g, 256'(rdy[g]), 256'(rem[g] == 0));
      check("busy", g, 256'(bsy[g]), 256'(rem[g] != 0));
      check("hash_valid", g, 256'(hv[g]), 256'(hvexp[g]));
      check("hash", g, hs[g], hexp[g]);
    end
  end

  task automatic send(input int g, input logic [511:0] d, input bit f,
                      input bit l, input bit m, output int acc);
    int n = 0;
    @(negedge clk);
    bv[g] = 1'b1; bd[g] = d; bf[g] = f; bl[g] = l; bm[g] = m;
    while (rdy[g] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (rdy[g] !== 1'b1) timeout("accept", g, n);
    @(posedge clk);
    #1 acc = cyc;
  endtask

  task automatic idle(input int g);
    @(negedge clk);
    bv[g] = 1'b0;
    bd[g] = rand512();
  endtask

  task automatic wait_hash(input int g, input int acc,
                           input logic [255:0] dig, input bit chk_dig);
    int n = 0;
    @(negedge clk);
    while (hv[g] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (hv[g] !== 1'b1) timeout("hash_valid", g, n);
    else begin
      check("latency", g, 256'(cyc - acc), 256'((64 >> g) + 1));
      if (chk_dig) check("digest", g, hs[g], dig);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog[u0] timeout: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, n, nb;
    bit f, l;
    bv = '0; bf = '0; bl = '0; bm = '0; bd = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("rst_ready", g, 256'(rdy[g]), 256'(1));
      check("rst_busy", g, 256'(bsy[g]), 256'(0));
      check("rst_hv", g, 256'(hv[g]), 256'(0));
      check("rst_hash", g, hs[g], 256'(0));
    end
    #2 reset_n = 1'b1;

    for (int g = 0; g < NI; g++) begin
      send(g, B_ABC, 1'b1, 1'b1, 1'b0, acc); idle(g);
      wait_hash(g, acc, D_ABC, 1'b1);
      send(g, B_ABC, 1'b1, 1'b1, 1'b1, acc); idle(g);
      wait_hash(g, acc, D_ABC224, 1'b1);
      send(g, B_EMPTY, 1'b1, 1'b1, 1'b0, acc); idle(g);
      wait_hash(g, acc, D_EMPTY, 1'b1);
      // second block's mode must be ignored
      send(g, B_TWO1, 1'b1, 1'b0, 1'b0, acc);
      send(g, B_TWO2, 1'b0, 1'b1, 1'b1, acc2); idle(g);
      check("b2b_gap", g, 256'(acc2 - acc), 256'((64 >> g) + 2));
      wait_hash(g, acc2, D_TWO, 1'b1);
    end

    send(0, B_ABC, 1'b1, 1'b1, 1'b0, acc); idle(0);
    repeat (29) @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    check("abort_ready", 0, 256'(rdy[0]), 256'(1));
    check("abort_hash", 0, hs[0], 256'(0));
    #2 reset_n = 1'b1;
    send(0, B_ABC, 1'b1, 1'b1, 1'b0, acc); idle(0);
    wait_hash(0, acc, D_ABC, 1'b1);

    send(0, B_ABC, 1'b1, 1'b1, 1'b0, acc);
    n = 0;
    @(negedge clk);
    while (rem[0] != 0 && n < 200) begin
      bv[0] = 1'($urandom); bd[0] = rand512();
      bf[0] = 1'($urandom); bl[0] = 1'($urandom); bm[0] = 1'($urandom);
      @(negedge clk);
      n++;
    end
    bv[0] = 1'b0;
    check("noise_hv", 0, 256'(hv[0]), 256'(1));
    check("noise_latency", 0, 256'(cyc - acc), 256'(65));
    check("noise_digest", 0, hs[0], D_ABC);

    for (int g = 0; g < NI; g++) begin
      for (int m = 0; m < 6; m++) begin
        nb = 1 + int'($urandom_range(0, 2));
        for (int b = 0; b < nb; b++) begin
          f = (b == 0) ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 9) == 0);
          l = (b == nb - 1);
          send(g, rand512(), f, l, 1'($urandom), acc);
          if (!l && $urandom_range(0, 1) == 1) begin
            idle(g);
            repeat ($urandom_range(0, 2)) @(negedge clk);
          end
        end
        idle(g);
        wait_hash(g, acc, 256'(0), 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
